// File: rtl/seq_multiplier.sv
// Sequential 32x32 unsigned shift-add multiplier with valid/ready handshakes.
// One partial-product addition per BUSY cycle; fixed 33-edge latency from accept to result.

module add32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | 32 shift-add iterations in progress
// DONE  | product valid, waiting for out_ready
module seq_multiplier (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state;
    logic [31:0] mcand;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  count;
    logic [31:0] sum;
    logic        cy;
    logic [32:0] partial;

    add32 u_add (
        .a    (hi),
        .b    (mcand),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cy)
    );

    // The carry becomes hi[31] after the shift, so the 64-bit product never overflows.
    assign partial = lo[0] ? {cy, sum} : {1'b0, hi};

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_BUSY);
    assign out_valid = (state == ST_DONE);
    assign result    = {hi, lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            mcand <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            count <= 5'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        mcand <= a;
                        hi    <= 32'd0;
                        lo    <= b;
                        count <= 5'd0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    {hi, lo} <= {partial, lo[31:1]};
                    count    <= count + 5'd1;
                    if (count == 5'd31) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Testbench for seq_multiplier: directed cases plus 1000 random operand pairs
// checked against a plain 64-bit multiply, with random result back-pressure.

module tb_seq_multiplier;
    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] result;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int accepts = 0;
    int handshakes = 0;

    seq_multiplier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake bookkeeping sees pre-edge values of registered outputs.
    always @(posedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) accepts++;
            if (out_valid && out_ready) handshakes++;
        end
    end

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xx;
        logic [63:0] yy;
        xx = {32'd0, x};
        yy = {32'd0, y};
        return xx * yy;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the first edge showing out_valid.
    task automatic wait_done(output int edges);
        edges = 1;
        while (edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (out_valid) break;
        end
    endtask

    // Called at a negedge with the DUT idle; runs one full operation.
    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input int stall,
                         input bit detailed);
        int edges;
        logic [63:0] exp;
        exp = ref_mul(x, y);
        chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        a = x;
        b = y;
        in_valid = 1'b1;
        out_ready = ($urandom_range(0, 1) == 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        if (detailed) begin
            chk("busy_after_accept", {63'd0, busy}, 64'd1);
            chk("in_ready_low_busy", {63'd0, in_ready}, 64'd0);
        end
        wait_done(edges);
        chk("latency_edges", 64'(edges), 64'd33);
        chk("product", result, exp);
        for (int k = 0; k < stall; k++) begin
            out_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("held_valid", {63'd0, out_valid}, 64'd1);
            chk("held_result", result, exp);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("valid_dropped", {63'd0, out_valid}, 64'd0);
        chk("in_ready_after_done", {63'd0, in_ready}, 64'd1);
        if (detailed) chk("result_retained", result, exp);
    endtask

    initial begin
        int edges;
        logic [31:0] x;
        logic [31:0] y;
        rst_n = 1'b0;
        a = 32'd0;
        b = 32'd0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(32'd3, 32'd5, 0, 1'b1);
        chk("small_product_const", result, 64'h0000_0000_0000_000F);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1);
        chk("max_product_const", result, 64'hFFFF_FFFE_0000_0001);
        do_op(32'h1234_5678, 32'd0, 5, 1'b1);
        do_op(32'd0, 32'hDEAD_BEEF, 1, 1'b1);

        // Operands presented during BUSY/DONE must be ignored.
        a = 32'd7;
        b = 32'd9;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 32'd2;
        b = 32'd2;
        wait_done(edges);
        chk("ignore_latency", 64'(edges), 64'd33);
        chk("ignore_product", result, 64'd63);
        @(posedge clk);
        @(negedge clk);
        chk("no_accept_on_done_edge", {63'd0, in_ready}, 64'd1);
        chk("result_kept_idle", result, 64'd63);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("second_accepted", {63'd0, busy}, 64'd1);
        wait_done(edges);
        chk("second_latency", 64'(edges), 64'd33);
        chk("second_product", result, 64'd4);
        @(posedge clk);
        @(negedge clk);

        // Abort mid-operation with asynchronous reset.
        a = 32'd10;
        b = 32'd10;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_result", result, 64'd0);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'd6, 32'd7, 0, 1'b1);
        chk("post_reset_product", result, 64'd42);

        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 7))
                0: x = 32'hFFFF_FFFF;
                1: x = 32'd0;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: y = 32'hFFFF_FFFF;
                1: y = 32'd1;
                default: y = $urandom;
            endcase
            do_op(x, y, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 1'b0);
        end

        chk("handshake_per_accept", 64'(handshakes), 64'(accepts - 1));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
